p12_cfg_sequencer: RTL and testbench

Configuration sequencer for the p12 tile array. It accepts a command naming a config plane (vertical, horizontal or diagonal flip, or state-only). It then streams CHAIN_LEN bits into the tile scan chain and pulses the matching config-latch enable while the array clock is frozen. It sits between the host bit-stream interface and the tile grid, and drives the grid-wide scan enable, the latch enables, the loop breaker and the array clock-gate enable.

---
 rtl/p12_cfg_sequencer.sv | 153 +++++++++++++++
 tb/tb_p12_cfg_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/p12_cfg_sequencer.sv
// p12_cfg_sequencer
// Streams a configuration plane into the p12 tile scan chain, then pulses
// the matching config-latch enable while the array clock is frozen. The
// loop breaker is forced on for the whole command.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for a command; array clock running, scan disabled
//   S_SHIFT | scan enabled; one chain bit per bit_valid/bit_ready handshake
//   S_SETUP | array frozen, scan still enabled, latches closed (guard cycle)
//   S_LATCH | array frozen, latch enable of the selected plane held high
//   S_HOLD  | array frozen, latches closed again (guard cycle)

module p12_cfg_sequencer #(
    parameter int CHAIN_LEN = 36,
    parameter int LAT_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_plane,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic       bit_data,
    output logic       rd_valid,
    output logic       rd_data,
    input  logic       lb_req,
    input  logic       sc_ret,
    output logic       se,
    output logic       sc,
    output logic       lat_v,
    output logic       lat_h,
    output logic       lat_d,
    output logic       lb,
    output logic       tile_clk_en,
    output logic       busy,
    output logic       done
);

    localparam logic [11:0] LP_CNT_LAST = 12'(CHAIN_LEN - 1);
    localparam logic [3:0]  LP_LAT_LOAD = 4'(LAT_CYC - 1);
    localparam logic [1:0]  LP_PLANE_V  = 2'd0;
    localparam logic [1:0]  LP_PLANE_H  = 2'd1;
    localparam logic [1:0]  LP_PLANE_D  = 2'd2;
    localparam logic [1:0]  LP_PLANE_S  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_SETUP = 3'd2,
        S_LATCH = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t      r_state;
    logic [11:0] r_cnt;
    logic [3:0]  r_lat_cnt;
    logic [1:0]  r_plane;
    logic        r_done;

    logic        w_in_idle;
    logic        w_in_shift;
    logic        w_in_latch;
    logic        w_handshake;
    logic        w_last_bit;

    assign w_in_idle   = (r_state == S_IDLE);
    assign w_in_shift  = (r_state == S_SHIFT);
    assign w_in_latch  = (r_state == S_LATCH);
    assign w_handshake = w_in_shift & bit_valid;
    assign w_last_bit  = (r_cnt == LP_CNT_LAST);

    // Sequencer FSM with bit counter, latch down-counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_lat_cnt <= '0;
            r_plane   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_plane <= cmd_plane;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_valid) begin
                        r_cnt <= r_cnt + 12'd1;
                        if (w_last_bit) begin
                            // State-only reload has no plane to latch.
                            if (r_plane == LP_PLANE_S) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_SETUP;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    r_lat_cnt <= LP_LAT_LOAD;
                    r_state   <= S_LATCH;
                end
                S_LATCH: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Array clock gate: free-running when idle, advances only on a handshake
    // while shifting, frozen around the latch pulse.
    always_comb begin
        tile_clk_en = 1'b0;
        case (r_state)
            S_IDLE:  tile_clk_en = 1'b1;
            S_SHIFT: tile_clk_en = bit_valid;
            default: tile_clk_en = 1'b0;
        endcase
    end

    assign cmd_ready = w_in_idle;
    assign bit_ready = w_in_shift;
    assign busy      = ~w_in_idle;
    assign se        = w_in_shift | (r_state == S_SETUP);
    assign lat_v     = w_in_latch & (r_plane == LP_PLANE_V);
    assign lat_h     = w_in_latch & (r_plane == LP_PLANE_H);
    assign lat_d     = w_in_latch & (r_plane == LP_PLANE_D);
    assign lb        = lb_req | ~w_in_idle;
    assign done      = r_done;

    assign sc        = bit_data;
    assign rd_valid  = w_handshake;
    assign rd_data   = sc_ret;

endmodule

// File: tb/tb_p12_cfg_sequencer.sv
// Directed bench for p12_cfg_sequencer. Two instances share all inputs:
// A uses LAT_CYC=1, B uses LAT_CYC=3; both use a 4-tile chain. The tile
// chain and the per-plane config latches are modelled here, driven by A.

module tb_p12_cfg_sequencer;

    logic clk = 1'b0;
    logic rst, cmd_valid, bit_valid, bit_data, lb_req, sc_ret;
    logic [1:0] cmd_plane;

    logic cmd_ready_a, bit_ready_a, rd_valid_a, rd_data_a, se_a, sc_a;
    logic lat_v_a, lat_h_a, lat_d_a, lb_a, tce_a, busy_a, done_a;
    logic cmd_ready_b, bit_ready_b, rd_valid_b, rd_data_b, se_b, sc_b;
    logic lat_v_b, lat_h_b, lat_d_b, lb_b, tce_b, busy_b, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    // tile[0] is the chain head, tile[3] the tail
    logic [3:0] tile = 4'b0000;
    logic [3:0] r_v  = 4'b0000;
    logic [3:0] r_h  = 4'b0000;
    logic [3:0] r_d  = 4'b0000;

    int n_lv_a, n_lh_a, n_ld_a, n_frz_a, done_cyc_a, done_cyc_b, n_lat_b;
    int viol, lb_bad;
    logic lb9;

    always #5 clk = ~clk;

    assign sc_ret = tile[3];

    always @(posedge clk) begin
        if (tce_a && se_a) tile <= {tile[2:0], sc_a};
        if (lat_v_a) r_v <= tile;
        if (lat_h_a) r_h <= tile;
        if (lat_d_a) r_d <= tile;
    end

    p12_cfg_sequencer #(.CHAIN_LEN(4), .LAT_CYC(1)) u_dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_a),
        .cmd_plane(cmd_plane), .bit_valid(bit_valid), .bit_ready(bit_ready_a),
        .bit_data(bit_data), .rd_valid(rd_valid_a), .rd_data(rd_data_a),
        .lb_req(lb_req), .sc_ret(sc_ret), .se(se_a), .sc(sc_a),
        .lat_v(lat_v_a), .lat_h(lat_h_a), .lat_d(lat_d_a), .lb(lb_a),
        .tile_clk_en(tce_a), .busy(busy_a), .done(done_a)
    );

    p12_cfg_sequencer #(.CHAIN_LEN(4), .LAT_CYC(3)) u_dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b),
        .cmd_plane(cmd_plane), .bit_valid(bit_valid), .bit_ready(bit_ready_b),
        .bit_data(bit_data), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
        .lb_req(lb_req), .sc_ret(sc_ret), .se(se_b), .sc(sc_b),
        .lat_v(lat_v_b), .lat_h(lat_h_b), .lat_d(lat_d_b), .lb(lb_b),
        .tile_clk_en(tce_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a command, shift 4 bits without stalls (bits[0] first), then
    // observe cycles 5..12 after acceptance and gather latch/done statistics.
    task automatic do_cmd(input logic [1:0] pl, input logic [3:0] bits,
                          input bit hold, input logic [1:0] hold_pl);
        cmd_valid = 1'b1;
        cmd_plane = pl;
        tick();
        if (hold) cmd_plane = hold_pl;
        else cmd_valid = 1'b0;
        #1;
        chk("accept_busy", busy_a, 1);
        chk("accept_cmd_ready", cmd_ready_a, 0);
        for (int k = 0; k < 4; k++) begin
            bit_valid = 1'b1;
            bit_data  = bits[k];
            #1;
            chk("shift_se", se_a, 1);
            chk("shift_bit_ready", bit_ready_a & bit_ready_b, 1);
            chk("shift_tce", tce_a & tce_b, 1);
            chk("shift_rd_valid", rd_valid_a & rd_valid_b, 1);
            chk("shift_sc", {sc_a, sc_b}, {bits[k], bits[k]});
            tick();
        end
        bit_valid = 1'b0;
        cmd_valid = 1'b0;
        n_lv_a = 0; n_lh_a = 0; n_ld_a = 0; n_frz_a = 0; n_lat_b = 0;
        done_cyc_a = 0; done_cyc_b = 0; viol = 0; lb_bad = 0; lb9 = 1'bx;
        for (int c = 5; c <= 12; c++) begin
            #1;
            if (lat_v_a) n_lv_a++;
            if (lat_h_a) n_lh_a++;
            if (lat_d_a) n_ld_a++;
            if (!tce_a) n_frz_a++;
            if (lat_v_b | lat_h_b | lat_d_b) n_lat_b++;
            if (done_a) done_cyc_a = c;
            if (done_b) done_cyc_b = c;
            if ((lat_v_a | lat_h_a | lat_d_a) && tce_a) viol++;
            if ((lat_v_b | lat_h_b | lat_d_b) && tce_b) viol++;
            if (busy_a && !lb_a) lb_bad++;
            if (c == 9) lb9 = lb_a;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_plane = 2'd0;
        bit_valid = 1'b0; bit_data = 1'b0; lb_req = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_cmd_ready", {cmd_ready_a, cmd_ready_b}, 2'b11);
        chk("rst_bit_ready", bit_ready_a, 0);
        chk("rst_se", se_a, 0);
        chk("rst_lat", {lat_v_a, lat_h_a, lat_d_a}, 3'b000);
        chk("rst_tce", tce_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_lb", lb_a, 0);
        rst = 1'b0;
        tick();

        // Plane V, bits 1,0,1,1, no stalls
        do_cmd(2'd0, 4'b1101, 1'b0, 2'd0);
        chk("v_lat_v_cycles", n_lv_a, 1);
        chk("v_lat_h_cycles", n_lh_a, 0);
        chk("v_lat_d_cycles", n_ld_a, 0);
        chk("v_frozen_cycles", n_frz_a, 3);
        chk("v_done_cycle_a", done_cyc_a, 8);
        chk("v_done_cycle_b", done_cyc_b, 10);
        chk("v_lat_cycles_b", n_lat_b, 3);
        chk("v_lat_while_clk", viol, 0);
        chk("v_lb_busy", lb_bad, 0);
        chk("v_lb_after_done", lb9, 0);
        chk("v_model_r_v", r_v, 4'b1011);

        // Plane 3 with toggling bit_valid, data 0,0,1,1 (preloads 1,1,0,0)
        cmd_valid = 1'b1;
        cmd_plane = 2'd3;
        tick();
        cmd_valid = 1'b0;
        begin
            logic [3:0] pre;
            int k;
            pre = 4'b1100;
            k = 0;
            for (int c = 1; c <= 7; c++) begin
                bit_valid = (c % 2 == 1);
                if (bit_valid) bit_data = pre[k];
                #1;
                chk("s3_tce", tce_a, bit_valid);
                chk("s3_rd_valid", rd_valid_a, bit_valid);
                chk("s3_no_lat", {lat_v_a, lat_h_a, lat_d_a, lat_v_b, lat_h_b, lat_d_b}, 6'd0);
                chk("s3_no_early_done", done_a, 0);
                if (bit_valid) k++;
                tick();
            end
        end
        bit_valid = 1'b0;
        #1;
        chk("s3_done_a", done_a, 1);
        chk("s3_done_b", done_b, 1);
        chk("s3_idle", busy_a, 0);
        chk("s3_tiles", tile, 4'b0011);
        chk("s3_r_v_kept", r_v, 4'b1011);
        tick();

        // Readback of the preloaded chain with lb_req held high
        lb_req = 1'b1;
        #1;
        chk("rb_lb_idle", lb_a, 1);
        cmd_valid = 1'b1;
        cmd_plane = 2'd3;
        tick();
        cmd_valid = 1'b0;
        begin
            logic [3:0] stream, exp_rd;
            stream = 4'b0101;
            exp_rd = 4'b1100;
            for (int k = 0; k < 4; k++) begin
                bit_valid = 1'b1;
                bit_data  = stream[k];
                #1;
                chk("rb_rd_data", {rd_data_a, rd_data_b}, {exp_rd[k], exp_rd[k]});
                chk("rb_lb", {lb_a, lb_b}, 2'b11);
                tick();
            end
        end
        bit_valid = 1'b0;
        #1;
        chk("rb_done", done_a, 1);
        chk("rb_lb_done", lb_a, 1);
        tick();
        lb_req = 1'b0;
        #1;
        chk("rb_lb_released", lb_a, 0);

        // Reset in the 2nd LATCH cycle of instance B (plane H)
        cmd_valid = 1'b1;
        cmd_plane = 2'd1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bit_valid = 1'b1;
            bit_data  = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("ab_lat_h_b_2nd", lat_h_b, 1);
        chk("ab_tce_b_frozen", tce_b, 0);
        rst = 1'b1;
        tick();
        #1;
        chk("ab_lat_b", {lat_v_b, lat_h_b, lat_d_b}, 3'b000);
        chk("ab_tce_b", tce_b, 1);
        chk("ab_se_b", se_b, 0);
        chk("ab_busy_b", busy_b, 0);
        chk("ab_cmd_ready_b", cmd_ready_b, 1);
        chk("ab_bit_ready_b", bit_ready_b, 0);
        chk("ab_no_done", {done_a, done_b}, 2'b00);
        rst = 1'b0;
        tick();
        #1;
        chk("ab_no_done_later", {done_a, done_b}, 2'b00);

        // Plane H with cmd_valid held during SHIFT naming plane D
        do_cmd(2'd1, 4'b0110, 1'b1, 2'd2);
        chk("h_lat_h_cycles", n_lh_a, 1);
        chk("h_lat_d_cycles", n_ld_a, 0);
        chk("h_lat_v_cycles", n_lv_a, 0);
        chk("h_done_cycle_a", done_cyc_a, 8);
        chk("h_done_cycle_b", done_cyc_b, 10);
        chk("h_lat_cycles_b", n_lat_b, 3);
        chk("h_lat_while_clk", viol, 0);
        chk("h_model_r_h", r_h, 4'b0110);
        chk("h_model_r_d", r_d, 4'b0000);
        chk("h_idle_end", {busy_a, busy_b}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
